// File: rtl/mig_pkg.sv
// Shared types and configuration for the MIG truth-table engine.
// Sizing is fixed here so every file agrees on operand and entry widths.
package mig_pkg;
   localparam int NUM_INPUTS     = 7;
   localparam int MAX_NODES      = 8;
   localparam int TT_W           = 1 << NUM_INPUTS;
   localparam int SEL_W          = $clog2(1 + NUM_INPUTS + MAX_NODES);
   localparam int ADDR_W         = $clog2(MAX_NODES);
   localparam int CNT_W          = $clog2(MAX_NODES + 1);
   localparam int SEL_CONST0     = 0;
   localparam int SEL_INPUT_BASE = 1;
   localparam int SEL_NODE_BASE  = NUM_INPUTS + 1;

   typedef struct packed {
      logic             inv;
      logic [SEL_W-1:0] sel;
   } operand_t;

   // Packed MSB-first so the raw entry reads {opC, opB, opA}.
   typedef struct packed {
      operand_t op_c;
      operand_t op_b;
      operand_t op_a;
   } node_t;

   typedef enum logic [1:0] {IDLE, EVAL, CAPTURE, DONE} state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction
endpackage

// File: rtl/mig_operand_mux.sv
// Resolves one {inv, sel} operand to a bit; illegal operands read as 0.
// limit is the first node index that may not be referenced.
module mig_operand_mux
   import mig_pkg::*;
(
   input  operand_t              op,
   input  logic [NUM_INPUTS-1:0] minterm,
   input  logic [MAX_NODES-1:0]  nodes,
   input  logic [CNT_W-1:0]      limit,
   output logic                  val,
   output logic                  illegal
);
   logic raw;

   always_comb begin
      raw     = 1'b0;
      illegal = 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++)
         if (int'(op.sel) == SEL_INPUT_BASE + i) raw = minterm[i];
      for (int j = 0; j < MAX_NODES; j++)
         if (int'(op.sel) == SEL_NODE_BASE + j) begin
            if (j < int'(limit)) raw = nodes[j];
            else                 illegal = 1'b1;
         end
      if (int'(op.sel) > SEL_NODE_BASE + MAX_NODES - 1) illegal = 1'b1;
      val = illegal ? 1'b0 : (raw ^ op.inv);
   end
endmodule

// File: rtl/mig_truth_table_engine.sv
// Programmable MIG evaluator: sweeps every minterm, one node per cycle,
// and hands the complete truth table out over a valid/ready handshake.
module mig_truth_table_engine
   import mig_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   prog_we,
   input  logic [ADDR_W-1:0]      prog_addr,
   input  logic [3*(SEL_W+1)-1:0] prog_data,
   input  logic [SEL_W:0]         out_sel,
   input  logic [CNT_W-1:0]       num_nodes,
   input  logic                   start,
   output logic                   busy,
   output logic                   err,
   output logic                   tt_valid,
   input  logic                   tt_ready,
   output logic [TT_W-1:0]        tt_data
);
   state_t                state;
   node_t                 mem [MAX_NODES];
   logic [MAX_NODES-1:0]  nodes;
   logic [NUM_INPUTS-1:0] m;
   logic [ADDR_W-1:0]     k;
   logic [CNT_W-1:0]      nn;
   operand_t              osel;
   node_t                 cur;
   operand_t [2:0]        node_ops;
   logic [2:0]            op_val, op_ill;
   logic                  out_val, out_ill;

   assign cur      = mem[k];
   assign node_ops = {cur.op_c, cur.op_b, cur.op_a};

   for (genvar i = 0; i < 3; i++) begin : g_node_op
      mig_operand_mux u_mux (
         .op(node_ops[i]), .minterm(m), .nodes(nodes), .limit(CNT_W'(k)),
         .val(op_val[i]), .illegal(op_ill[i])
      );
   end

   // Output operand may reference any active node, hence limit = nn.
   mig_operand_mux u_out_mux (
      .op(osel), .minterm(m), .nodes(nodes), .limit(nn),
      .val(out_val), .illegal(out_ill)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         err      <= 1'b0;
         tt_valid <= 1'b0;
         tt_data  <= '0;
         nodes    <= '0;
         m        <= '0;
         k        <= '0;
         nn       <= '0;
         osel     <= '0;
         for (int i = 0; i < MAX_NODES; i++) mem[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (prog_we) mem[prog_addr] <= prog_data;
               if (start) begin
                  osel <= out_sel;
                  nn   <= num_nodes;
                  m    <= '0;
                  k    <= '0;
                  if (int'(num_nodes) > MAX_NODES) begin
                     err <= 1'b1;
                  end else begin
                     err   <= 1'b0;
                     busy  <= 1'b1;
                     state <= (num_nodes == '0) ? CAPTURE : EVAL;
                  end
               end
            end
            EVAL: begin
               nodes[k] <= maj3(op_val[0], op_val[1], op_val[2]);
               if (|op_ill) err <= 1'b1;
               if (CNT_W'(k) == nn - CNT_W'(1)) state <= CAPTURE;
               else                             k     <= k + ADDR_W'(1);
            end
            CAPTURE: begin
               tt_data[m] <= out_val;
               if (out_ill) err <= 1'b1;
               k <= '0;
               if (&m) begin
                  state    <= DONE;
                  tt_valid <= 1'b1;
               end else begin
                  m     <= m + NUM_INPUTS'(1);
                  state <= (nn == '0) ? CAPTURE : EVAL;
               end
            end
            DONE: begin
               if (tt_ready) begin
                  tt_valid <= 1'b0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mig_truth_table_engine.sv
// Scoreboard bench for mig_truth_table_engine: expected tables queued at
// start, popped and compared when tt_valid rises.
module tb_mig_truth_table_engine;
   import mig_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   prog_we;
   logic [ADDR_W-1:0]      prog_addr;
   logic [3*(SEL_W+1)-1:0] prog_data;
   logic [SEL_W:0]         out_sel;
   logic [CNT_W-1:0]       num_nodes;
   logic                   start;
   logic                   busy, err, tt_valid, tt_ready;
   logic [TT_W-1:0]        tt_data;

   typedef struct {
      logic [TT_W-1:0] tt;
      logic            err;
      int              lat;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   localparam int XB = SEL_INPUT_BASE;
   localparam int NB = SEL_NODE_BASE;

   always #5 clk = ~clk;

   mig_truth_table_engine dut (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .out_sel(out_sel), .num_nodes(num_nodes),
      .start(start), .busy(busy), .err(err), .tt_valid(tt_valid),
      .tt_ready(tt_ready), .tt_data(tt_data)
   );

   task automatic chk(input string tag, input logic [TT_W-1:0] got, input logic [TT_W-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [SEL_W:0] op(input bit inv, input int sel);
      return {inv, SEL_W'(sel)};
   endfunction

   task automatic prog(input int a, input logic [SEL_W:0] oa, input logic [SEL_W:0] ob,
                       input logic [SEL_W:0] oc);
      @(negedge clk);
      prog_we = 1'b1; prog_addr = ADDR_W'(a); prog_data = {oc, ob, oa};
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic sweep(input string tag, input logic [SEL_W:0] osel, input int nn,
                        input logic [TT_W-1:0] ett, input logic eerr, input int hold,
                        input bit disturb);
      exp_t            e;
      int              lat;
      logic [TT_W-1:0] snap;
      logic            stable;
      sb.push_back('{ett, eerr, TT_W * (nn + 1) + 1});
      @(negedge clk);
      out_sel = osel; num_nodes = CNT_W'(nn); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      while (!tt_valid && lat < TT_W * (MAX_NODES + 1) + 20) begin
         if (disturb && lat == 50) begin
            prog_we = 1'b1; prog_addr = ADDR_W'(5); prog_data = '1;
            start = 1'b1; out_sel = '0; num_nodes = CNT_W'(9);
         end else begin
            prog_we = 1'b0; start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      e = sb.pop_front();
      chk({tag, " tt_data"}, tt_data, e.tt);
      chk({tag, " err"}, TT_W'(err), TT_W'(e.err));
      chk({tag, " latency"}, TT_W'(lat), TT_W'(e.lat));
      chk({tag, " busy in done"}, TT_W'(busy), TT_W'(1));
      if (hold > 0) begin
         snap   = tt_data;
         stable = 1'b1;
         repeat (hold) begin
            @(negedge clk);
            if (!tt_valid || tt_data !== snap) stable = 1'b0;
         end
         chk({tag, " hold stable"}, TT_W'(stable), TT_W'(1));
      end
      tt_ready = 1'b1;
      @(negedge clk);
      tt_ready = 1'b0;
      chk({tag, " valid drop"}, TT_W'(tt_valid), TT_W'(0));
      chk({tag, " busy drop"}, TT_W'(busy), TT_W'(0));
   endtask

   initial begin
      rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      out_sel = '0; num_nodes = '0; start = 1'b0; tt_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset busy", TT_W'(busy), TT_W'(0));
      chk("reset err", TT_W'(err), TT_W'(0));
      chk("reset valid", TT_W'(tt_valid), TT_W'(0));
      chk("reset tt_data", tt_data, TT_W'(0));
      rst = 1'b0;

      sweep("x0 identity", op(0, XB + 0), 0, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA, 1'b0, 20, 1'b0);
      sweep("not const0", op(1, SEL_CONST0), 0, '1, 1'b0, 0, 1'b0);

      prog(0, op(0, XB + 0), op(0, XB + 1), op(0, XB + 2));
      sweep("maj3", op(0, NB + 0), 1, {16{8'hE8}}, 1'b0, 0, 1'b0);
      sweep("maj3 inv", op(1, NB + 0), 1, {16{8'h17}}, 1'b0, 0, 1'b0);

      prog(0, op(0, XB + 4), op(0, XB + 5), op(0, XB + 6));
      prog(1, op(0, XB + 0), op(0, XB + 3), op(0, XB + 4));
      prog(2, op(0, XB + 1), op(0, XB + 2), op(0, XB + 5));
      prog(3, op(0, XB + 2), op(0, XB + 3), op(0, NB + 2));
      prog(4, op(0, XB + 1), op(0, NB + 0), op(0, NB + 1));
      prog(5, op(0, XB + 0), op(0, NB + 3), op(0, NB + 4));
      tt_ready = 1'b1;
      sweep("six node", op(0, NB + 5), 6, 128'hfeeaeee8faeaa880feeaa8a0e888a880, 1'b0, 0, 1'b1);

      // node1 = MAJ(x3, node3 -> 0, ~0) = x3
      prog(1, op(0, XB + 3), op(0, NB + 3), op(1, SEL_CONST0));
      sweep("forward ref", op(0, NB + 1), 2, {8{16'hFF00}}, 1'b1, 0, 1'b0);

      @(negedge clk);
      num_nodes = CNT_W'(9); out_sel = op(0, XB); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("too many nodes err", TT_W'(err), TT_W'(1));
      chk("too many nodes busy", TT_W'(busy), TT_W'(0));
      repeat (3) @(negedge clk);
      chk("too many nodes idle", TT_W'(busy | tt_valid), TT_W'(0));

      sweep("err cleared", op(0, XB + 0), 0, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA, 1'b0, 0, 1'b0);

      // Mid-sweep reset during a program that raises err via the forward reference.
      @(negedge clk);
      out_sel = op(0, NB + 5); num_nodes = CNT_W'(6); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (40 * 7 - 1) @(negedge clk);
      chk("pre-reset busy", TT_W'(busy), TT_W'(1));
      rst = 1'b1;
      #1;
      chk("abort busy", TT_W'(busy), TT_W'(0));
      chk("abort valid", TT_W'(tt_valid), TT_W'(0));
      chk("abort err", TT_W'(err), TT_W'(0));
      chk("abort tt_data", tt_data, TT_W'(0));
      @(negedge clk);
      rst = 1'b0;

      sweep("cleared memory", op(0, NB + 5), 6, '0, 1'b0, 0, 1'b0);
      sweep("const0", op(0, SEL_CONST0), 0, '0, 1'b0, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mig_truth_table_engine.md
Name: mig_truth_table_engine

Overview:
- Programmable majority-inverter-graph (MIG) evaluator.
- Holds a small netlist of 3-input majority nodes with complemented edges.
- Sweeps all 2^NUM_INPUTS minterms, evaluating one node per cycle, and emits the function's full truth table as one word over a valid/ready handshake.
- Sits behind the classification flow: replaces per-function hard-wired majority networks, so any candidate network can be checked against its target truth table in hardware.

Parameters:
- NUM_INPUTS, 7, number of primary inputs x0..x(N-1); truth table width TT_W = 2^NUM_INPUTS.
- MAX_NODES, 8, capacity of the node program memory.
- SEL_W, clog2(1+NUM_INPUTS+MAX_NODES), operand select width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- prog_we  in  1  write one node entry (ignored while busy)
- prog_addr  in  clog2(MAX_NODES)  node index to write
- prog_data  in  3*(SEL_W+1)  {opC, opB, opA}; each op = {inv, sel}
- out_sel  in  SEL_W+1  {inv, sel} of the function output; sampled at start
- num_nodes  in  clog2(MAX_NODES+1)  active node count; sampled at start
- start  in  1  begin sweep (accepted only in IDLE)
- busy  out  1  high in EVAL/CAPTURE/DONE
- err  out  1  sticky illegal-program flag; cleared on accepted start
- tt_valid  out  1  truth table available
- tt_ready  in  1  consumer accepts truth table
- tt_data  out  TT_W  bit m = f(minterm m); x_i = bit i of m (x0 = LSB)

Behaviour:
- Select encoding:
  - 0 = constant 0.
  - 1..N = x0..x(N-1).
  - N+1+j = node j output.
  - inv complements the operand.
- Node value: MAJ(a,b,c) = ab | ac | bc of the possibly-complemented operands.
- Reset (async):
  - state IDLE; busy=0, err=0, tt_valid=0, tt_data=0.
  - Program memory cleared to all-zero entries.
  - Node registers, minterm and node counters cleared.
  - Reset mid-sweep aborts with no output.
- States:
  - IDLE: start=1 latches out_sel and num_nodes, clears err, sets m=0 and k=0.
    - num_nodes > MAX_NODES: err=1, stay IDLE.
    - num_nodes = 0: go to CAPTURE.
    - Otherwise: go to EVAL.
  - EVAL: each cycle computes node k from the current minterm, inputs and node registers, and writes node register k.
    - k == num_nodes-1: go to CAPTURE.
    - Otherwise: k++.
  - CAPTURE: evaluates the out_sel operand and writes tt_data[m].
    - m == TT_W-1: go to DONE.
    - Otherwise: m++, k=0, go to EVAL (or stay in CAPTURE when num_nodes=0).
  - DONE: tt_valid=1 and tt_data stable until tt_ready=1. On that cycle tt_valid drops next edge, go to IDLE.
- Latency: start to tt_valid = TT_W*(num_nodes+1)+1 cycles (including the DONE entry edge).
- Illegal operand sets err=1 (sticky); the operand evaluates as 0 and the sweep continues. An operand is illegal if it:
  - references node j >= k (forward or self reference), or
  - references node j >= num_nodes at CAPTURE, or
  - has sel > NUM_INPUTS+MAX_NODES.
- prog_we while busy: ignored, no error.
- start while busy: ignored.
- start with tt_ready held high: DONE lasts exactly one cycle.
- out_sel/num_nodes changes during a sweep: no effect.

Decomposition:
- Shared package mig_pkg:
  - operand struct {inv, sel}
  - node entry struct {opA, opB, opC}
  - SEL_CONST0 = 0, SEL_INPUT_BASE = 1, SEL_NODE_BASE = NUM_INPUTS+1
  - state enum {IDLE, EVAL, CAPTURE, DONE}
  - function maj3
- One sub-module, mig_operand_mux: given an operand, minterm, node register vector and current k, returns the value and an illegal flag. Instantiated 3x for nodes and 1x for the output.

Test Plan:
- Zero-node identity: N=7, num_nodes=0, out_sel={0,1} (x0) -> tt_data = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, err=0, latency 129 cycles. out_sel={1,0} -> all ones.
- Single majority: NUM_INPUTS=3, node0=MAJ(x0,x1,x2), num_nodes=1, out=node0 -> tt_data = 8'hE8; with out inv=1 -> 8'h17.
- Six-node network, N=7:
  - Nodes: w0=MAJ(x4,x5,x6), w1=MAJ(x0,x3,x4), w2=MAJ(x1,x2,x5), w3=MAJ(x2,x3,w2), w4=MAJ(x1,w0,w1), w5=MAJ(x0,w3,w4); out=w5.
  - Expect tt_data = 128'hfeeaeee8faeaa880feeaa8a0e888a880, err=0, latency 7*128+1.
- Handshake: hold tt_ready=0 for 20 cycles after tt_valid -> tt_valid and tt_data stable throughout. Pulse tt_ready -> tt_valid low next cycle, busy low. prog_we and start pulsed during the sweep have no effect.
- Errors:
  - node1 operand references node 3 -> err=1, sweep completes.
  - num_nodes=9 with MAX_NODES=8 -> err=1, busy stays 0.
  - Next legal start clears err.
- Reset mid-sweep: assert rst at minterm 40 -> busy, tt_valid, err and tt_data all 0 immediately. Program memory cleared; a fresh start with num_nodes=0, out=const0 yields all zeros.
